// File: rtl/dispatch_order_select_if.sv
// Decode-queue heads, issue-queue write ports and their ready/valid handshakes
// between the dispatch selector (slave) and its neighbours (master).
interface dispatch_order_select_if #(
  parameter int UOP_W = 160,
  parameter int NDEST = 4
);
  logic [1:0]                  lane_valid_i;
  logic [1:0][UOP_W-1:0]       lane_uop_i;
  logic [1:0][NDEST-1:0]       lane_dest_i;
  logic [1:0]                  lane_ready_o;
  logic                        rob_empty_i;
  logic [NDEST-1:0]            iq_ready_i;
  logic [NDEST-1:0]            iq_valid_o;
  logic [NDEST-1:0][UOP_W-1:0] iq_uop_o;

  modport slave (
    input  lane_valid_i, lane_uop_i, lane_dest_i, rob_empty_i, iq_ready_i,
    output lane_ready_o, iq_valid_o, iq_uop_o
  );

  modport master (
    output lane_valid_i, lane_uop_i, lane_dest_i, rob_empty_i, iq_ready_i,
    input  lane_ready_o, iq_valid_o, iq_uop_o
  );
endinterface

// File: rtl/dispatch_order_select.sv
// In-order dual-issue selector: pops up to two oldest micro-ops from the two
// alternating decode lanes and registers them onto one-hot issue-queue ports.
module dispatch_order_select #(
  parameter int UOP_W = 160,
  parameter int NDEST = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  flush_i,
  dispatch_order_select_if.slave dif,
  output logic [31:0]           stall_cnt_o
);

  localparam int          SYS_BIT = 3;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic is_onehot(input logic [NDEST-1:0] v);
    return (v != '0) && ((v & (v - NDEST'(1))) == '0);
  endfunction

  logic                        rptr_q, rptr_d;
  logic [NDEST-1:0]            iq_valid_q, iq_valid_d;
  logic [NDEST-1:0][UOP_W-1:0] iq_uop_q, iq_uop_d;
  logic [31:0]                 stall_cnt_q, stall_cnt_d;

  logic             slot0_valid, slot1_valid;
  logic [NDEST-1:0] dest0, dest1;
  logic [UOP_W-1:0] uop0, uop1;
  logic             fire0, fire1, d0, d1;
  logic [1:0]       lane_ready;

  // Slot0 is always the older op; the lane holding it is named by rptr.
  always_comb begin
    slot0_valid = dif.lane_valid_i[rptr_q];
    slot1_valid = dif.lane_valid_i[~rptr_q];
    dest0       = dif.lane_dest_i[rptr_q];
    dest1       = dif.lane_dest_i[~rptr_q];
    uop0        = dif.lane_uop_i[rptr_q];
    uop1        = dif.lane_uop_i[~rptr_q];
  end

  // An illegal (zero or multi-hot) destination simply never becomes ready.
  always_comb begin
    fire0 = slot0_valid
         && is_onehot(dest0)
         && ((dest0 & dif.iq_ready_i) != '0)
         && (!dest0[SYS_BIT] || dif.rob_empty_i);
    d0    = fire0 && !flush_i && !arst_i;

    fire1 = slot1_valid
         && is_onehot(dest1)
         && ((dest1 & dif.iq_ready_i) != '0)
         && (dest1 != dest0)
         && !dest0[SYS_BIT]
         && !dest1[SYS_BIT];
    d1    = d0 && fire1;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lane_ready          = '0;
    lane_ready[rptr_q]  = d0;
    lane_ready[~rptr_q] = d1;
  end

  assign dif.lane_ready_o = lane_ready;

  always_comb begin
    rptr_d = flush_i ? 1'b0 : (rptr_q ^ (d0 ^ d1));

    iq_valid_d = '0;
    iq_uop_d   = iq_uop_q;
    for (int k = 0; k < NDEST; k++) begin
      if (d0 && dest0[k]) begin
        iq_valid_d[k] = 1'b1;
        iq_uop_d[k]   = uop0;
      end else if (d1 && dest1[k]) begin
        iq_valid_d[k] = 1'b1;
        iq_uop_d[k]   = uop1;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (slot0_valid && !d0 && !flush_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // NOTE: the wide payload registers are reset too, because downstream sees a defined all-zero state out of reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rptr_q      <= 1'b0;
      iq_valid_q  <= '0;
      iq_uop_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
      rptr_q      <= rptr_d;
      iq_valid_q  <= iq_valid_d;
      iq_uop_q    <= iq_uop_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dif.iq_valid_o = iq_valid_q;
  assign dif.iq_uop_o   = iq_uop_q;
  assign stall_cnt_o    = stall_cnt_q;

`ifndef SYNTHESIS
  a_lane0_dest_onehot : assert property (@(posedge clk_i) disable iff (arst_i)
    dif.lane_valid_i[0] |-> is_onehot(dif.lane_dest_i[0]));
  a_lane1_dest_onehot : assert property (@(posedge clk_i) disable iff (arst_i)
    dif.lane_valid_i[1] |-> is_onehot(dif.lane_dest_i[1]));
`endif

endmodule

// File: tb/tb_dispatch_order_select.sv
// Directed scenario bench for dispatch_order_select: popped ops are pushed to a
// scoreboard and matched against the registered issue-queue writes a cycle later.
module tb_dispatch_order_select;

  localparam int UOP_W = 160;
  localparam int NDEST = 4;

  localparam logic [3:0] D_INT = 4'b0001;
  localparam logic [3:0] D_MEM = 4'b0010;
  localparam logic [3:0] D_FP  = 4'b0100;
  localparam logic [3:0] D_SYS = 4'b1000;

  typedef struct {
    int               dest;
    logic [UOP_W-1:0] uop;
  } sb_entry_t;

  logic        clk;
  logic        arst;
  logic        flush;
  logic [31:0] stall_cnt;

  dispatch_order_select_if #(.UOP_W(UOP_W), .NDEST(NDEST)) dif ();

  dispatch_order_select #(.UOP_W(UOP_W), .NDEST(NDEST)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .flush_i     (flush),
    .dif         (dif),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                          n_cmp = 0;
  int                          n_err = 0;
  sb_entry_t                   sb[$];
  logic [NDEST-1:0][UOP_W-1:0] shadow;
  logic [31:0]                 exp_stall;
  logic [UOP_W-1:0]            u [0:31];

  task automatic check(input string tag, input logic [UOP_W-1:0] got, input logic [UOP_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [UOP_W-1:0] mk_uop();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int dest_idx(input logic [3:0] d);
    int r = 0;
    for (int k = 0; k < NDEST; k++) if (d[k]) r = k;
    return r;
  endfunction

  task automatic set_lane(input int n, input bit v, input logic [3:0] d, input logic [UOP_W-1:0] uop);
    dif.lane_valid_i[n] = v;
    dif.lane_dest_i[n]  = d;
    dif.lane_uop_i[n]   = uop;
  endtask

  // Called just after a falling edge with stimulus already applied.
  task automatic cycle(input string tag, input logic [1:0] exp_rdy, input logic [3:0] exp_vld,
                       input bit stall_inc);
    sb_entry_t e;
    #1;
    check({tag, "/rdy"}, UOP_W'(dif.lane_ready_o), UOP_W'(exp_rdy));
    for (int n = 0; n < 2; n++) begin
      if (exp_rdy[n]) begin
        e.dest = dest_idx(dif.lane_dest_i[n]);
        e.uop  = dif.lane_uop_i[n];
        sb.push_back(e);
      end
    end
    if (stall_inc && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
    @(posedge clk);
    #1;
    check({tag, "/vld"}, UOP_W'(dif.iq_valid_o), UOP_W'(exp_vld));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "/wr"}, UOP_W'(dif.iq_valid_o[e.dest]), UOP_W'(1'b1));
      shadow[e.dest] = e.uop;
    end
    for (int k = 0; k < NDEST; k++) check({tag, "/uop"}, dif.iq_uop_o[k], shadow[k]);
    check({tag, "/stall"}, UOP_W'(stall_cnt), UOP_W'(exp_stall));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) u[i] = mk_uop();
    shadow    = '0;
    exp_stall = '0;

    arst  = 1'b1;
    flush = 1'b0;
    dif.rob_empty_i = 1'b1;
    dif.iq_ready_i  = 4'b1111;
    set_lane(0, 1'b1, D_INT, u[0]);
    set_lane(1, 1'b1, D_MEM, u[1]);
    @(negedge clk);
    @(negedge clk);
    check("rst/rdy",   UOP_W'(dif.lane_ready_o), '0);
    check("rst/vld",   UOP_W'(dif.iq_valid_o), '0);
    check("rst/uop",   UOP_W'(dif.iq_uop_o), '0);
    check("rst/stall", UOP_W'(stall_cnt), '0);
    arst = 1'b0;

    // Dual dispatch with rptr at 0.
    set_lane(0, 1'b1, D_INT, u[0]);  set_lane(1, 1'b1, D_MEM, u[1]);
    cycle("dual_a", 2'b11, 4'b0011, 1'b0);
    set_lane(0, 1'b1, D_INT, u[2]);  set_lane(1, 1'b1, D_FP,  u[3]);
    cycle("dual_b", 2'b11, 4'b0101, 1'b0);

    // Same-destination conflict: one op per cycle, rptr toggles.
    set_lane(0, 1'b1, D_INT, u[4]);  set_lane(1, 1'b1, D_INT, u[5]);
    cycle("conf_a", 2'b01, 4'b0001, 1'b0);
    set_lane(0, 1'b1, D_INT, u[6]);
    cycle("conf_b", 2'b10, 4'b0001, 1'b0);
    set_lane(1, 1'b0, D_INT, u[7]);
    cycle("conf_c", 2'b01, 4'b0001, 1'b0);

    // SYS in slot0 waits for ROB drain, then dispatches alone.
    dif.rob_empty_i = 1'b0;
    set_lane(1, 1'b1, D_SYS, u[8]);  set_lane(0, 1'b1, D_INT, u[9]);
    for (int i = 0; i < 3; i++) cycle("sys_wait", 2'b00, 4'b0000, 1'b1);
    dif.rob_empty_i = 1'b1;
    cycle("sys_go", 2'b10, 4'b1000, 1'b0);
    set_lane(1, 1'b0, D_INT, u[10]);
    cycle("sys_next", 2'b01, 4'b0001, 1'b0);

    // SYS in slot1 is held back behind an ordinary op.
    set_lane(1, 1'b1, D_INT, u[11]); set_lane(0, 1'b1, D_SYS, u[12]);
    cycle("sys1_a", 2'b10, 4'b0001, 1'b0);
    set_lane(1, 1'b0, D_INT, u[13]);
    cycle("sys1_b", 2'b01, 4'b1000, 1'b0);

    // Blocked oldest op must also block the younger one.
    dif.iq_ready_i = 4'b1011;
    set_lane(1, 1'b1, D_FP, u[14]);  set_lane(0, 1'b1, D_INT, u[15]);
    cycle("blk_a", 2'b00, 4'b0000, 1'b1);
    cycle("blk_b", 2'b00, 4'b0000, 1'b1);
    dif.iq_ready_i = 4'b1111;
    cycle("blk_go", 2'b11, 4'b0101, 1'b0);

    // Flush with rptr at 1: no pop, valids clear, rptr returns to 0.
    flush = 1'b1;
    set_lane(1, 1'b1, D_INT, u[16]); set_lane(0, 1'b1, D_MEM, u[17]);
    cycle("flush", 2'b00, 4'b0000, 1'b0);
    flush = 1'b0;
    set_lane(0, 1'b1, D_INT, u[18]); set_lane(1, 1'b1, D_INT, u[19]);
    cycle("post_flush", 2'b01, 4'b0001, 1'b0);

    // Asynchronous reset while write strobes are active.
    set_lane(1, 1'b1, D_MEM, u[20]); set_lane(0, 1'b1, D_INT, u[21]);
    cycle("pre_arst", 2'b11, 4'b0011, 1'b0);
    #2;
    arst = 1'b1;
    #1;
    check("arst/vld",   UOP_W'(dif.iq_valid_o), '0);
    check("arst/uop",   UOP_W'(dif.iq_uop_o), '0);
    check("arst/stall", UOP_W'(stall_cnt), '0);
    check("arst/rdy",   UOP_W'(dif.lane_ready_o), '0);
    @(negedge clk);
    arst      = 1'b0;
    shadow    = '0;
    exp_stall = '0;
    sb.delete();
    set_lane(0, 1'b1, D_INT, u[22]); set_lane(1, 1'b1, D_INT, u[23]);
    cycle("post_arst", 2'b01, 4'b0001, 1'b0);

    // Counter saturation with slot0 (lane1) blocked on FP.
    dif.iq_ready_i = 4'b1011;
    set_lane(1, 1'b1, D_FP, u[24]);  set_lane(0, 1'b1, D_INT, u[25]);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    exp_stall = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) cycle("sat", 2'b00, 4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
